// File: rtl/alu_mul_seq_pkg.sv
// alu_mul_seq_pkg: shared FSM state encodings and ALU select codes for the sequential multiplier
package alu_mul_seq_pkg;

    localparam int DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 8-bit shift-and-add multiplier borrowing an external shared ALU for each add step.
// Build option MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter logic [2:0] ADD_SEL = ALU_ADD,
    parameter int         NSTEPS  = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic [DW-1:0] MCAND,
    input  logic [DW-1:0] MPLIER,
    output logic          BUSY,
    output logic          DONE,
    output logic [DW-1:0] PRODUCT,
    output logic          ALU_REQ,
    input  logic          ALU_GNT,
    output logic [DW-1:0] ALU_DATA1,
    output logic [DW-1:0] ALU_DATA2,
    output logic [2:0]    ALU_SELECT,
    input  logic [DW-1:0] ALU_RESULT
);

    state_e        state_q;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] mc_q, mc_d;
    logic [DW-1:0] mp_q, mp_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] product_q;
    logic          last;

    // Next values for one granted step; the add result is only taken when the current multiplier bit is set
    always_comb begin
        acc_d = mp_q[0] ? ALU_RESULT : acc_q;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + 4'd1;
`ifdef MUL_EARLY_EXIT_EN
        last  = (mp_d == '0);
`else
        last  = (cnt_q == 4'(NSTEPS - 1));
`endif
    end

    // Control FSM; a stalled RUN cycle (no grant) leaves every register untouched
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mc_q      <= '0;
            mp_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (START) begin
                    state_q <= ST_RUN;
                    acc_q   <= '0;
                    mc_q    <= MCAND;
                    mp_q    <= MPLIER;
                    cnt_q   <= '0;
                end
                ST_RUN: if (ALU_GNT) begin
                    acc_q <= acc_d;
                    mc_q  <= mc_d;
                    mp_q  <= mp_d;
                    cnt_q <= cnt_d;
                    if (last) begin
                        state_q   <= ST_DONE;
                        product_q <= acc_d;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign BUSY       = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign DONE       = (state_q == ST_DONE);
    assign PRODUCT    = product_q;
    assign ALU_REQ    = (state_q == ST_RUN);
    assign ALU_DATA1  = ALU_REQ ? acc_q : '0;
    assign ALU_DATA2  = ALU_REQ ? mc_q : '0;
    assign ALU_SELECT = ALU_REQ ? ADD_SEL : ALU_FWD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed self-checking bench for alu_mul_seq with a behavioural shared ALU.
// Honours MUL_EARLY_EXIT_EN for expected step counts.
module tb_alu_mul_seq;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [7:0] MCAND;
    logic [7:0] MPLIER;
    logic       BUSY;
    logic       DONE;
    logic [7:0] PRODUCT;
    logic       ALU_REQ;
    logic       ALU_GNT;
    logic [7:0] ALU_DATA1;
    logic [7:0] ALU_DATA2;
    logic [2:0] ALU_SELECT;
    logic [7:0] ALU_RESULT;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mul_seq dut (
        .CLK(CLK), .RESET(RESET), .START(START), .MCAND(MCAND), .MPLIER(MPLIER),
        .BUSY(BUSY), .DONE(DONE), .PRODUCT(PRODUCT), .ALU_REQ(ALU_REQ), .ALU_GNT(ALU_GNT),
        .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT), .ALU_RESULT(ALU_RESULT)
    );

    always #5 CLK = ~CLK;

    // Shared ALU: adds when the add code is selected, otherwise returns 0
    assign ALU_RESULT = (ALU_SELECT == 3'b001) ? 8'(ALU_DATA1 + ALU_DATA2) : 8'h00;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_steps(input logic [7:0] b);
        int n;
        n = 8;
`ifdef MUL_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
`endif
        return n;
    endfunction

    // One multiply: stall_n grant-low cycles starting at RUN cycle stall_at; optional ignored START at inj_at
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_p,
                           input int stall_at, input int stall_n, input int inj_at);
        int lat;
        logic stall;
        logic [7:0] d1, d2;
        lat = 0;
        @(negedge CLK);
        MCAND = a; MPLIER = b; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("run_req", 32'(ALU_REQ), 1);
        check("run_sel", 32'(ALU_SELECT), 1);
        check("run_d1", 32'(ALU_DATA1), 0);
        check("run_d2", 32'(ALU_DATA2), 32'(a));
        while (!DONE && lat < 60) begin
            stall = (lat >= stall_at) && (lat < stall_at + stall_n);
            ALU_GNT = !stall;
            if (lat == inj_at) begin
                START = 1'b1; MCAND = 8'h33; MPLIER = 8'h03;
            end
            d1 = ALU_DATA1;
            d2 = ALU_DATA2;
            @(negedge CLK);
            lat++;
            START = 1'b0;
            if (stall) begin
                check("stall_d1", 32'(ALU_DATA1), 32'(d1));
                check("stall_d2", 32'(ALU_DATA2), 32'(d2));
                check("stall_req", 32'(ALU_REQ), 1);
            end
        end
        ALU_GNT = 1'b1;
        check("done_seen", 32'(DONE), 1);
        check("latency", lat, exp_steps(b) + stall_n);
        check("product", 32'(PRODUCT), 32'(exp_p));
        check("busy_done", 32'(BUSY), 1);
        check("req_done", 32'(ALU_REQ), 0);
        @(negedge CLK);
        check("done_pulse", 32'(DONE), 0);
        check("busy_idle", 32'(BUSY), 0);
        check("product_hold", 32'(PRODUCT), 32'(exp_p));
        check("d1_idle", 32'(ALU_DATA1), 0);
        check("sel_idle", 32'(ALU_SELECT), 0);
    endtask

    initial begin
        logic extra;
        RESET = 1'b0; START = 1'b0; MCAND = 8'h00; MPLIER = 8'h00; ALU_GNT = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        check("rst_busy", 32'(BUSY), 0);
        check("rst_done", 32'(DONE), 0);
        check("rst_product", 32'(PRODUCT), 0);
        check("rst_req", 32'(ALU_REQ), 0);
        check("rst_sel", 32'(ALU_SELECT), 0);
        check("rst_d1", 32'(ALU_DATA1), 0);
        check("rst_d2", 32'(ALU_DATA2), 0);

        run_mul(8'd5, 8'd3, 8'd15, -1, 0, -1);
        run_mul(8'hFF, 8'hFF, 8'h01, -1, 0, -1);
        run_mul(8'h80, 8'h02, 8'h00, -1, 0, -1);
        run_mul(8'd7, 8'd9, 8'd63, 1, 3, -1);
        run_mul(8'd0, 8'd0, 8'd0, -1, 0, -1);
        run_mul(8'd6, 8'd7, 8'd42, -1, 0, 2);

        extra = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE || BUSY) extra = 1'b1;
        end
        check("no_extra_run", 32'(extra), 0);

        @(negedge CLK);
        MCAND = 8'd12; MPLIER = 8'd10; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        check("abort_busy", 32'(BUSY), 0);
        check("abort_done", 32'(DONE), 0);
        check("abort_product", 32'(PRODUCT), 0);
        check("abort_req", 32'(ALU_REQ), 0);
        check("abort_d2", 32'(ALU_DATA2), 0);
        @(negedge CLK);
        check("abort_no_done", 32'(DONE), 0);
        run_mul(8'd12, 8'd10, 8'd120, -1, 0, -1);

        @(negedge CLK);
        RESET = 1'b0; START = 1'b1; MCAND = 8'd1; MPLIER = 8'd1;
        @(negedge CLK);
        RESET = 1'b1; START = 1'b0;
        check("rst_over_start_busy", 32'(BUSY), 0);
        check("rst_over_start_product", 32'(PRODUCT), 0);

        ALU_GNT = 1'b0;
        repeat (2) @(negedge CLK);
        check("gnt_idle_req", 32'(ALU_REQ), 0);
        ALU_GNT = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 Parameter: ADD_SEL, 3'b001, ALU select code for add driven on ALU_SELECT during a step.
REQ-002 Parameter: NSTEPS, 8, multiplier bit count (fixed at 8 for the 8-bit ALU).
REQ-003 CLK  in  1  single clock; all state on rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-low.
REQ-005 START  in  1  one-cycle request to begin a multiply.
REQ-006 MCAND  in  8  multiplicand, sampled on accepted START.
REQ-007 MPLIER  in  8  multiplier, sampled on accepted START.
REQ-008 BUSY  out  1  high while a multiply is in progress (RUN or DONE state).
REQ-009 DONE  out  1  one-cycle pulse; PRODUCT valid.
REQ-010 PRODUCT  out  8  low 8 bits of MCAND*MPLIER; held until next accepted START.
REQ-011 ALU_REQ  out  1  request for the shared ALU; high in RUN only.
REQ-012 ALU_GNT  in  1  grant from the datapath owner; a step completes only on an edge with ALU_GNT=1.
REQ-013 ALU_DATA1 / ALU_DATA2  out  8 each  operands: accumulator / shifted multiplicand.
REQ-014 ALU_SELECT  out  3  ADD_SEL in RUN, 3'b000 otherwise.
REQ-015 ALU_RESULT  in  8  ALU combinational result, sampled on the step edge; ALU add settles within one CLK period.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on START=1; RUN->DONE after final step; DONE->IDLE unconditionally next edge.
REQ-017 On accepted START: acc<=0, mc<=MCAND, mp<=MPLIER, step count<=0.
REQ-018 START outside IDLE ignored; no queuing; operands not resampled.
REQ-019 Each RUN edge with ALU_GNT=1 is one step: if mp[0]=1 then acc<=ALU_RESULT else acc unchanged; mc<=mc<<1 (zero fill); mp<=mp>>1; count increments.
REQ-020 RUN edge with ALU_GNT=0: all state held; ALU_REQ stays high; operand outputs stable.
REQ-021 Product truncated to 8 bits; bits shifted out of mc discarded; no overflow indication.
REQ-022 Latency with continuous grant: START edge E0, steps E1..E8, DONE=1 and PRODUCT updated during cycle after E8, BUSY low after E9.
REQ-023 PRODUCT<=acc on RUN->DONE transition; unchanged at all other times.
REQ-024 ALU_DATA1=acc, ALU_DATA2=mc in RUN; both 0 outside RUN.
REQ-025 ALU_GNT ignored outside RUN.

Reset
REQ-026 RESET=0 at a rising edge: state IDLE; BUSY=0, DONE=0, PRODUCT=0, ALU_REQ=0, ALU_SELECT=000, ALU_DATA1/2=0, acc/mc/mp/count=0.
REQ-027 Reset mid-RUN or in DONE aborts; no DONE pulse; PRODUCT cleared to 0.
REQ-028 RESET dominates START on the same edge.

Configuration
REQ-029 Macro MUL_EARLY_EXIT_EN defined: RUN->DONE on the step edge where mp after shifting equals 0, so latency = index of highest set MPLIER bit + 1 steps; MPLIER=0 takes 1 step, product 0.
REQ-030 Macro undefined: always exactly NSTEPS granted steps regardless of operands.

Structure
REQ-031 Shared package holds FSM state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and ALU select constants (FWD=000, ADD=001, AND=010, OR=011).
REQ-032 Single module, no sub-module; the ALU stays external and is shared through ALU_REQ/ALU_GNT.

Verification
REQ-033 MCAND=5, MPLIER=3, ALU_GNT=1 -> DONE pulse cycle after E8, PRODUCT=15 (early-exit build: after E2).
REQ-034 MCAND=0xFF, MPLIER=0xFF -> PRODUCT=0x01 (truncation); MCAND=0x80, MPLIER=0x02 -> PRODUCT=0x00.
REQ-035 MCAND=7, MPLIER=9, ALU_GNT low on 3 RUN cycles -> DONE delayed exactly 3 cycles, PRODUCT=63, outputs stable while stalled.
REQ-036 Second START pulse during RUN with different operands -> ignored, PRODUCT from first operands, no extra DONE.
REQ-037 RESET=0 at step 4 of 12*10 -> next edge IDLE, all outputs 0, no DONE; new START then gives PRODUCT=120.
REQ-038 MPLIER=0 -> PRODUCT=0; early-exit build 1 step, otherwise 8.
